// File: rtl/reset_sequencer.sv
// Power-on / lock-loss / button / software reset sequencer. It qualifies PLL lock,
// holds both resets, then releases the peripheral reset ahead of the SoC reset.
module reset_sequencer #(
  parameter int LOCK_STABLE     = 64,
  parameter int HOLD_CYCLES     = 128,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       ext_rst_n,
  input  logic       sw_rst_req,
  output logic       periph_reset,
  output logic       soc_reset,
  output logic       ready,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count
);

  localparam int MAX_A = (LOCK_STABLE > HOLD_CYCLES) ? LOCK_STABLE : HOLD_CYCLES;
  localparam int MAX_B = (STAGGER_CYCLES > DEBOUNCE_CYCLES) ? STAGGER_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST   = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    HOLD       = 3'd2,
    REL_PERIPH = 3'd3,
    RUN        = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          lock_meta_r;
  logic          lock_s;
  logic          btn_meta_r;
  logic          btn_s;
  logic [CW-1:0] deb_cnt_r;
  logic          deb_fired_r;
  logic          press_s;
  logic          restart_s;
  logic [1:0]    restart_cause_s;

  // Two-flop synchronizers; reset value 0 means "unlocked" and "button pressed".
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_r <= 1'b0;
      lock_s      <= 1'b0;
      btn_meta_r  <= 1'b0;
      btn_s       <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock;
      lock_s      <= lock_meta_r;
      btn_meta_r  <= ext_rst_n;
      btn_s       <= btn_meta_r;
    end
  end

  // Button debounce counter; the fired flag limits it to one press per low period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt_r   <= CNT_ZERO;
      deb_fired_r <= 1'b0;
    end else if (btn_s) begin
      deb_cnt_r   <= CNT_ZERO;
      deb_fired_r <= 1'b0;
    end else begin
      if (deb_cnt_r != DEB_LAST) begin
        deb_cnt_r <= deb_cnt_r + CNT_ONE;
      end
      if (press_s) begin
        deb_fired_r <= 1'b1;
      end
    end
  end

  // Reset-request decode; a press outranks a software request.
  always_comb begin
    press_s         = 1'b0;
    restart_s       = 1'b0;
    restart_cause_s = 2'b11;
    if (!btn_s && (deb_cnt_r == DEB_LAST) && !deb_fired_r) begin
      press_s = 1'b1;
    end else begin
      press_s = 1'b0;
    end
    restart_s = press_s | sw_rst_req;
    if (press_s) begin
      restart_cause_s = 2'b10;
    end else begin
      restart_cause_s = 2'b11;
    end
  end

  // Sequencer FSM; outputs are registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= WAIT_LOCK;
      cnt_r        <= CNT_ZERO;
      periph_reset <= 1'b1;
      soc_reset    <= 1'b1;
      ready        <= 1'b0;
      reset_cause  <= 2'b00;
      reset_count  <= 8'd0;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_r <= STABLE;
            cnt_r   <= CNT_ZERO;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_r     <= WAIT_LOCK;
            cnt_r       <= CNT_ZERO;
            reset_cause <= 2'b01;
          end else if (cnt_r == STABLE_LAST) begin
            state_r <= HOLD;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HOLD, REL_PERIPH, RUN: begin
          if (!lock_s || restart_s) begin
            state_r      <= lock_s ? HOLD : WAIT_LOCK;
            cnt_r        <= CNT_ZERO;
            periph_reset <= 1'b1;
            soc_reset    <= 1'b1;
            ready        <= 1'b0;
            reset_cause  <= lock_s ? restart_cause_s : 2'b01;
            if ((state_r == RUN) && (reset_count != 8'd255)) begin
              reset_count <= reset_count + 8'd1;
            end
          end else if ((state_r == HOLD) && (cnt_r == HOLD_LAST)) begin
            state_r      <= REL_PERIPH;
            cnt_r        <= CNT_ZERO;
            periph_reset <= 1'b0;
          end else if ((state_r == REL_PERIPH) && (cnt_r == STAG_LAST)) begin
            state_r   <= RUN;
            cnt_r     <= CNT_ZERO;
            soc_reset <= 1'b0;
            ready     <= 1'b1;
          end else if (state_r != RUN) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r      <= WAIT_LOCK;
          cnt_r        <= CNT_ZERO;
          periph_reset <= 1'b1;
          soc_reset    <= 1'b1;
          ready        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small parameters; edge 0 is the first
// clock edge after an input change, expected edges are worked out by hand.
module tb_reset_sequencer;

  logic       clock;
  logic       reset_n;
  logic       pll_lock;
  logic       ext_rst_n;
  logic       sw_rst_req;
  logic       periph_reset;
  logic       soc_reset;
  logic       ready;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  int n_tests = 0;
  int n_fail  = 0;

  reset_sequencer #(
    .LOCK_STABLE    (8),
    .HOLD_CYCLES    (8),
    .STAGGER_CYCLES (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .ext_rst_n   (ext_rst_n),
    .sw_rst_req  (sw_rst_req),
    .periph_reset(periph_reset),
    .soc_reset   (soc_reset),
    .ready       (ready),
    .reset_cause (reset_cause),
    .reset_count (reset_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(ready), 32'd1);
  endtask

  // Called right after the lock input rises: periph falls at edge 18, soc/ready at edge 22.
  task automatic expect_release(input string tag);
    repeat (18) tick();
    check_eq({tag, "_periph_e17"}, 32'(periph_reset), 32'd1);
    tick();
    check_eq({tag, "_periph_e18"}, 32'(periph_reset), 32'd0);
    check_eq({tag, "_soc_e18"}, 32'(soc_reset), 32'd1);
    repeat (3) tick();
    check_eq({tag, "_soc_e21"}, 32'(soc_reset), 32'd1);
    check_eq({tag, "_ready_e21"}, 32'(ready), 32'd0);
    tick();
    check_eq({tag, "_soc_e22"}, 32'(soc_reset), 32'd0);
    check_eq({tag, "_ready_e22"}, 32'(ready), 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    ext_rst_n  = 1'b1;
    sw_rst_req = 1'b0;
    repeat (3) tick();
    check_eq("rst_periph", 32'(periph_reset), 32'd1);
    check_eq("rst_soc", 32'(soc_reset), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_cause", 32'(reset_cause), 32'd0);
    check_eq("rst_count", 32'(reset_count), 32'd0);

    // Power-on with lock already high
    pll_lock = 1'b1;
    tick();
    reset_n = 1'b1;
    expect_release("por");
    check_eq("por_cause", 32'(reset_cause), 32'd0);
    check_eq("por_count", 32'(reset_count), 32'd0);

    // Lock loss in RUN: resets assert on the third edge
    pll_lock = 1'b0;
    repeat (2) tick();
    check_eq("ll_periph_e1", 32'(periph_reset), 32'd0);
    check_eq("ll_ready_e1", 32'(ready), 32'd1);
    tick();
    check_eq("ll_periph_e2", 32'(periph_reset), 32'd1);
    check_eq("ll_soc_e2", 32'(soc_reset), 32'd1);
    check_eq("ll_ready_e2", 32'(ready), 32'd0);
    check_eq("ll_cause", 32'(reset_cause), 32'd1);
    check_eq("ll_count", 32'(reset_count), 32'd1);
    repeat (2) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (2) tick();
    pll_lock = 1'b1;
    expect_release("relock");
    check_eq("relock_cause", 32'(reset_cause), 32'd1);

    // Short button glitch: 3 low cycles never qualify
    ext_rst_n = 1'b0;
    repeat (3) tick();
    ext_rst_n = 1'b1;
    repeat (10) tick();
    check_eq("glitch_ready", 32'(ready), 32'd1);
    check_eq("glitch_count", 32'(reset_count), 32'd1);

    // Real press: 6 low cycles, HOLD entered on edge 5
    ext_rst_n = 1'b0;
    repeat (5) tick();
    check_eq("press_ready_e4", 32'(ready), 32'd1);
    tick();
    ext_rst_n = 1'b1;
    check_eq("press_ready_e5", 32'(ready), 32'd0);
    check_eq("press_periph_e5", 32'(periph_reset), 32'd1);
    check_eq("press_cause", 32'(reset_cause), 32'd2);
    check_eq("press_count", 32'(reset_count), 32'd2);
    repeat (7) tick();
    check_eq("press_periph_e12", 32'(periph_reset), 32'd1);
    tick();
    check_eq("press_periph_e13", 32'(periph_reset), 32'd0);
    repeat (4) tick();
    check_eq("press_ready_e17", 32'(ready), 32'd1);
    check_eq("press_count_once", 32'(reset_count), 32'd2);

    // Press and software request on the same edge: press wins
    ext_rst_n = 1'b0;
    repeat (5) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    ext_rst_n  = 1'b1;
    check_eq("both_ready", 32'(ready), 32'd0);
    check_eq("both_cause", 32'(reset_cause), 32'd2);
    check_eq("both_count", 32'(reset_count), 32'd3);
    wait_ready("both_rerun", 40);

    // Software reset, then a second request after 4 HOLD edges delays release by 4
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check_eq("sw_cause", 32'(reset_cause), 32'd3);
    check_eq("sw_count", 32'(reset_count), 32'd4);
    check_eq("sw_periph", 32'(periph_reset), 32'd1);
    repeat (3) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check_eq("sw_restart_count", 32'(reset_count), 32'd4);
    repeat (4) tick();
    check_eq("sw_periph_e8", 32'(periph_reset), 32'd1);
    repeat (3) tick();
    check_eq("sw_periph_e11", 32'(periph_reset), 32'd1);
    tick();
    check_eq("sw_periph_e12", 32'(periph_reset), 32'd0);
    repeat (4) tick();
    check_eq("sw_ready_e16", 32'(ready), 32'd1);

    // Saturate the exit counter
    for (int i = 0; i < 300; i++) begin
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      wait_ready("sat_rerun", 30);
    end
    check_eq("sat_count", 32'(reset_count), 32'd255);

    // Asynchronous reset in the middle of REL_PERIPH
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (8) tick();
    check_eq("mid_rel_periph", 32'(periph_reset), 32'd0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_periph", 32'(periph_reset), 32'd1);
    check_eq("async_soc", 32'(soc_reset), 32'd1);
    check_eq("async_ready", 32'(ready), 32'd0);
    check_eq("async_cause", 32'(reset_cause), 32'd0);
    check_eq("async_count", 32'(reset_count), 32'd0);
    reset_n = 1'b1;

    // One-cycle lock dropout during STABLE restarts qualification
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    expect_release("drop");
    check_eq("drop_cause", 32'(reset_cause), 32'd1);
    check_eq("drop_count", 32'(reset_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE, default 64: cycles of continuous synchronized PLL lock required before reset sequencing.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 128: cycles both reset outputs are held after lock is qualified or after a reset request.
REQ-003 The block SHALL have parameter STAGGER_CYCLES, default 16: cycles between periph_reset release and soc_reset release.
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 1024: cycles ext_rst_n must be sampled low before it counts as a press.
REQ-005 The block SHALL have port clock, input, 1 bit: sole clock, from the PLL output.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port pll_lock, input, 1 bit: asynchronous PLL lock indication.
REQ-008 The block SHALL have port ext_rst_n, input, 1 bit: asynchronous active-low board button.
REQ-009 The block SHALL have port sw_rst_req, input, 1 bit: synchronous single-cycle software reset request from the SoC.
REQ-010 The block SHALL have port periph_reset, output, 1 bit: active-high reset for UART/LED peripherals.
REQ-011 The block SHALL have port soc_reset, output, 1 bit: active-high reset for the SoC core.
REQ-012 The block SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-013 The block SHALL have port reset_cause, output, 2 bits: 00 POR, 01 lock loss, 10 button, 11 software.
REQ-014 The block SHALL have port reset_count, output, 8 bits: saturating count of exits from RUN.

Function
REQ-015 pll_lock and ext_rst_n SHALL each pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized values (lock_s, btn_s).
REQ-016 The FSM SHALL have states WAIT_LOCK, STABLE, HOLD, REL_PERIPH and RUN; all outputs SHALL be registered and change on the same edge as the state.
REQ-017 WAIT_LOCK SHALL go to STABLE, with the counter cleared, on the first edge that samples lock_s=1.
REQ-018 STABLE SHALL last exactly LOCK_STABLE cycles of lock_s=1 and then enter HOLD; lock_s=0 at any point SHALL return it to WAIT_LOCK.
REQ-019 HOLD SHALL last HOLD_CYCLES cycles, then REL_PERIPH; on entry to REL_PERIPH, periph_reset SHALL go 0.
REQ-020 REL_PERIPH SHALL last STAGGER_CYCLES cycles, then RUN; on entry to RUN, soc_reset SHALL go 0 and ready SHALL go 1.
REQ-021 periph_reset SHALL be 1 in WAIT_LOCK, STABLE and HOLD; soc_reset SHALL be 1 in every state except RUN.
REQ-022 Debounce SHALL be a counter that increments while btn_s=0 and clears when btn_s=1; a press SHALL be a single pulse when the count reaches DEBOUNCE_CYCLES-1, with no further pulse until btn_s returns high.
REQ-023 From RUN, lock_s=0 SHALL enter WAIT_LOCK with cause 01.
REQ-024 From RUN, a press SHALL enter HOLD with cause 10.
REQ-025 From RUN, sw_rst_req SHALL enter HOLD with cause 11.
REQ-026 Priority on simultaneous events SHALL be lock loss > press > software.
REQ-027 In STABLE, HOLD and REL_PERIPH, lock_s=0 SHALL force WAIT_LOCK with cause 01.
REQ-028 In HOLD and REL_PERIPH, a press or sw_rst_req SHALL restart HOLD with the counter zeroed, reasserting periph_reset, and update the cause.
REQ-029 In WAIT_LOCK and STABLE, a press or sw_rst_req SHALL be ignored.
REQ-030 reset_count SHALL increment on every exit from RUN and saturate at 255.
REQ-031 Counters SHALL be sized by $clog2 of the largest parameter and SHALL never wrap mid-state.

Reset
REQ-032 While reset_n=0: state WAIT_LOCK, periph_reset=1, soc_reset=1, ready=0, reset_cause=00, reset_count=0, synchronizers=0 (lock low, button pressed-safe), all counters 0.
REQ-033 reset_n assertion SHALL take effect asynchronously mid-sequence; deassertion SHALL be sampled by clock.

Verification (params LOCK_STABLE=8, HOLD_CYCLES=8, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=4)
REQ-034 POR with pll_lock high from edge 0 -> periph_reset falls at edge 18, soc_reset and ready change at edge 22, cause=00, count=0.
REQ-035 pll_lock drops for 1 cycle during STABLE -> sequence restarts; periph_reset falls 18 edges after lock returns.
REQ-036 In RUN, pll_lock low -> resets assert 3 edges later, cause=01, count=1; full sequence repeats on relock.
REQ-037 In RUN, ext_rst_n low for 3 cycles -> no effect; low for 6 cycles -> HOLD, cause=10, one count increment only.
REQ-038 In RUN, sw_rst_req and press on the same edge -> cause=10; sw_rst_req during HOLD -> HOLD restarts, periph release delayed by the elapsed hold cycles.
REQ-039 Force 300 RUN exits -> reset_count=255; reset_n pulse mid-REL_PERIPH -> periph_reset=1 immediately, cause=00, count=0.
